// File: rtl/chip8_sprite_draw_if.sv
// Bundle of the CPU command, sprite-memory and framebuffer byte-port signals for the DXYN engine.
interface chip8_sprite_draw_if #(
  parameter int ADDR_W = 12
);
  logic              start;
  logic [7:0]        vx;
  logic [7:0]        vy;
  logic [3:0]        n;
  logic [ADDR_W-1:0] i_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [7:0]        fbvx_read;
  logic [7:0]        fbvy_read;
  logic [7:0]        fb_readdata;
  logic [7:0]        fbvx_write;
  logic [7:0]        fbvy_write;
  logic [7:0]        fbdata;
  logic              write;
  logic              busy;
  logic              done;
  logic              collision;

  modport master (
    output start, vx, vy, n, i_addr, mem_rdata, fb_readdata,
    input  mem_addr, fbvx_read, fbvy_read, fbvx_write, fbvy_write, fbdata,
           write, busy, done, collision
  );

  modport slave (
    input  start, vx, vy, n, i_addr, mem_rdata, fb_readdata,
    output mem_addr, fbvx_read, fbvy_read, fbvx_write, fbvy_write, fbdata,
           write, busy, done, collision
  );
endinterface

// File: rtl/chip8_sprite_draw.sv
// CHIP-8 DXYN sprite draw: per row, fetch the sprite byte and an 8-pixel framebuffer
// window, XOR the right-edge-clipped sprite into it and write it back, tracking VF.
module chip8_sprite_draw #(
  parameter int FB_W   = 64,
  parameter int FB_H   = 32,
  parameter int ADDR_W = 12
) (
  input  logic               clk,
  input  logic               reset,
  chip8_sprite_draw_if.slave bus
);

  typedef enum logic [2:0] {IDLE, READ, CALC, WRITE, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        x0;
  logic [7:0]        y0;
  logic [3:0]        n_r;
  logic [3:0]        row;
  logic [ADDR_W-1:0] base;
  logic              hit;
  logic [7:0]        vx_mod;
  logic [7:0]        vy_mod;
  logic [7:0]        mask;
  logic              last_row;

  // The window is pinned inside the screen; sprites overhanging the right edge are clipped.
  function automatic logic [7:0] window_x(input logic [7:0] x);
    return (int'(x) <= FB_W - 8) ? x : 8'(FB_W - 8);
  endfunction

  function automatic logic [7:0] wrap_y(input logic [7:0] y, input logic [3:0] r);
    return 8'((int'(y) + int'(r)) % FB_H);
  endfunction

  // Sprite bit 7 is the leftmost pixel but window bit 0 is; reverse, then shift by the offset.
  function automatic logic [7:0] row_mask(input logic [7:0] spr, input logic [2:0] s);
    logic [7:0] rev;
    for (int j = 0; j < 8; j++) rev[j] = spr[7-j];
    return rev << s;
  endfunction

  assign vx_mod   = 8'(int'(bus.vx) % FB_W);
  assign vy_mod   = 8'(int'(bus.vy) % FB_H);
  assign mask     = row_mask(bus.mem_rdata, 3'(x0 - bus.fbvx_read));
  assign last_row = (row == 4'(n_r - 4'd1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    bus.write = 1'b0;
    unique case (state)
      IDLE:  if (bus.start) state_nxt = (bus.n == 4'd0) ? DONE : READ;
      READ:  begin bus.busy = 1'b1; state_nxt = CALC; end
      CALC:  begin bus.busy = 1'b1; state_nxt = WRITE; end
      WRITE: begin
        bus.busy  = 1'b1;
        bus.write = 1'b1;
        state_nxt = last_row ? DONE : READ;
      end
      DONE:  begin bus.done = 1'b1; state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x0             <= '0;
      y0             <= '0;
      n_r            <= '0;
      row            <= '0;
      base           <= '0;
      hit            <= 1'b0;
      bus.collision  <= 1'b0;
      bus.mem_addr   <= '0;
      bus.fbvx_read  <= '0;
      bus.fbvy_read  <= '0;
      bus.fbvx_write <= '0;
      bus.fbvy_write <= '0;
      bus.fbdata     <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          x0            <= vx_mod;
          y0            <= vy_mod;
          n_r           <= bus.n;
          base          <= bus.i_addr;
          row           <= '0;
          bus.collision <= 1'b0;
          if (bus.n != 4'd0) begin
            bus.mem_addr  <= bus.i_addr;
            bus.fbvx_read <= window_x(vx_mod);
            bus.fbvy_read <= vy_mod;
          end
        end
        // Sprite byte and old window arrive here, one cycle after their addresses.
        CALC: begin
          bus.fbdata     <= bus.fb_readdata ^ mask;
          hit            <= |(bus.fb_readdata & mask);
          bus.fbvx_write <= bus.fbvx_read;
          bus.fbvy_write <= bus.fbvy_read;
        end
        WRITE: begin
          bus.collision <= bus.collision | hit;
          if (!last_row) begin
            row           <= 4'(row + 4'd1);
            bus.mem_addr  <= ADDR_W'(base + ADDR_W'(row) + ADDR_W'(1));
            bus.fbvy_read <= wrap_y(y0, 4'(row + 4'd1));
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_sprite_draw.sv
// Directed bench for chip8_sprite_draw with memory/framebuffer models and a write scoreboard.
module tb_chip8_sprite_draw;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  wr_t  exp_q[$];

  logic [7:0]  mem [4096];
  logic [63:0] fb_row [32];
  logic        fb_clr  = 1'b0;
  logic        poke_en = 1'b0;
  int          poke_x  = 0;
  int          poke_y  = 0;

  chip8_sprite_draw_if #(.ADDR_W(12)) bus ();

  chip8_sprite_draw #(.FB_W(64), .FB_H(32), .ADDR_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] fb_window(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] w;
    w = '0;
    for (int i = 0; i < 8; i++)
      if (int'(x) + i < 64 && int'(y) < 32) w[i] = fb_row[y][int'(x) + i];
    return w;
  endfunction

  // Sprite memory and framebuffer, both with one cycle of read latency.
  always @(posedge clk) begin
    bus.mem_rdata   <= mem[bus.mem_addr];
    bus.fb_readdata <= fb_window(bus.fbvx_read, bus.fbvy_read);
    if (fb_clr) begin
      for (int y = 0; y < 32; y++) fb_row[y] <= '0;
    end else if (poke_en) begin
      fb_row[poke_y][poke_x] <= 1'b1;
    end
    if (bus.write && int'(bus.fbvy_write) < 32)
      for (int i = 0; i < 8; i++)
        if (int'(bus.fbvx_write) + i < 64)
          fb_row[bus.fbvy_write][int'(bus.fbvx_write) + i] <= bus.fbdata[i];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (bus.write === 1'b1) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_bad++;
        $error("FAIL unexpected_write: observed x=%0d y=%0d data=%02h expected no write",
               bus.fbvx_write, bus.fbvy_write, bus.fbdata);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("write_x", 32'(bus.fbvx_write), 32'(e.x));
        check("write_y", 32'(bus.fbvy_write), 32'(e.y));
        check("write_data", 32'(bus.fbdata), 32'(e.d));
      end
    end
  endtask

  task automatic fb_clear();
    @(negedge clk);
    fb_clr = 1'b1;
    @(posedge clk);
    #1 fb_clr = 1'b0;
  endtask

  task automatic fb_poke(input int x, input int y);
    @(negedge clk);
    poke_x  = x;
    poke_y  = y;
    poke_en = 1'b1;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic launch(input logic [7:0] x, input logic [7:0] y, input logic [3:0] nn,
                        input logic [11:0] ia);
    @(negedge clk);
    bus.vx     = x;
    bus.vy     = y;
    bus.n      = nn;
    bus.i_addr = ia;
    bus.start  = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic run_draw(input string tag, input logic [7:0] x, input logic [7:0] y,
                          input logic [3:0] nn, input logic [11:0] ia,
                          input int exp_cyc, input logic exp_coll);
    int   cyc;
    logic got;
    cyc = 0;
    got = 1'b0;
    launch(x, y, nn, ia);
    while (cyc < 100 && !got) begin
      tick();
      cyc++;
      if (cyc == 1) check({tag, "_busy_c1"}, 32'(bus.busy), 32'(nn != 4'd0));
      if (bus.done === 1'b1) got = 1'b1;
    end
    check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'(0));
    check({tag, "_collision"}, 32'(bus.collision), 32'(exp_coll));
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'(0));
    tick();
    check({tag, "_done_pulse_len"}, 32'(bus.done), 32'(0));
    check({tag, "_collision_held"}, 32'(bus.collision), 32'(exp_coll));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic done_seen;
    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
    bus.start       = 1'b0;
    bus.vx          = '0;
    bus.vy          = '0;
    bus.n           = '0;
    bus.i_addr      = '0;
    reset           = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_write", 32'(bus.write), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_collision", 32'(bus.collision), 32'(0));
    check("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
    check("rst_read_win", {16'(0), bus.fbvx_read, bus.fbvy_read}, 32'(0));
    check("rst_write_win", {8'(0), bus.fbvx_write, bus.fbvy_write, bus.fbdata}, 32'(0));
    reset = 1'b0;
    fb_clear();

    // Single row onto a blank screen, then the same draw erases it.
    mem[12'h200] = 8'hF0;
    exp_q.push_back('{x: 8'd0, y: 8'd0, d: 8'h0F});
    run_draw("t1", 8'd0, 8'd0, 4'd1, 12'h200, 4, 1'b0);
    exp_q.push_back('{x: 8'd0, y: 8'd0, d: 8'h00});
    run_draw("t2", 8'd0, 8'd0, 4'd1, 12'h200, 4, 1'b1);

    // Right-edge clip: pixels 56 and 58 pre-set must survive, 60..63 get set.
    mem[12'h300] = 8'hFF;
    fb_poke(56, 0);
    fb_poke(58, 0);
    exp_q.push_back('{x: 8'd56, y: 8'd0, d: 8'hF5});
    run_draw("t3", 8'd60, 8'd0, 4'd1, 12'h300, 4, 1'b0);

    // Clipped sprite landing on a lit pixel at x=62.
    mem[12'h310] = 8'hC3;
    fb_poke(62, 5);
    exp_q.push_back('{x: 8'd56, y: 8'd5, d: 8'h80});
    run_draw("clip_coll", 8'd62, 8'd5, 4'd1, 12'h310, 4, 1'b1);

    // n = 0 clears a previously set collision and writes nothing.
    run_draw("t5", 8'd10, 8'd10, 4'd0, 12'h200, 1, 1'b0);

    // Both coordinates wrap; rows wrap vertically from 31 to 0.
    fb_clear();
    mem[12'h400] = 8'h81;
    mem[12'h401] = 8'h3C;
    mem[12'h402] = 8'hFF;
    mem[12'h403] = 8'h01;
    exp_q.push_back('{x: 8'd6, y: 8'd30, d: 8'h81});
    exp_q.push_back('{x: 8'd6, y: 8'd31, d: 8'h3C});
    exp_q.push_back('{x: 8'd6, y: 8'd0,  d: 8'hFF});
    exp_q.push_back('{x: 8'd6, y: 8'd1,  d: 8'h80});
    run_draw("t4", 8'd70, 8'd30, 4'd4, 12'h400, 13, 1'b0);

    // Reset during CALC of row 2 of a 5-row draw that has already collided.
    for (int a = 0; a < 5; a++) mem[12'h500 + a] = 8'h80;
    fb_poke(0, 10);
    exp_q.push_back('{x: 8'd0, y: 8'd10, d: 8'h00});
    exp_q.push_back('{x: 8'd0, y: 8'd11, d: 8'h01});
    launch(8'd0, 8'd10, 4'd5, 12'h500);
    for (int c = 1; c <= 8; c++) tick();
    check("t6_collision_before_reset", 32'(bus.collision), 32'(1));
    check("t6_calc_no_write", 32'(bus.write), 32'(0));
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    check("t6_write_after_reset", 32'(bus.write), 32'(0));
    check("t6_busy_after_reset", 32'(bus.busy), 32'(0));
    check("t6_collision_after_reset", 32'(bus.collision), 32'(0));
    done_seen = bus.done;
    for (int c = 0; c < 20; c++) begin
      tick();
      done_seen = done_seen | bus.done;
    end
    check("t6_no_done_pulse", 32'(done_seen), 32'(0));
    check("t6_rows_written", 32'(exp_q.size()), 32'(0));

    // Restart after the abort, with the sprite address wrapping past 0xFFF.
    mem[12'hFFF] = 8'hAA;
    mem[12'h000] = 8'h55;
    exp_q.push_back('{x: 8'd8, y: 8'd20, d: 8'h55});
    exp_q.push_back('{x: 8'd8, y: 8'd21, d: 8'hAA});
    run_draw("t6_restart", 8'd8, 8'd20, 4'd2, 12'hFFF, 7, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
